w_tracker: RTL and testbench
============================

W_TRACKER -- requirements
Module: w_tracker

Interface
REQ-001 Parameter WIDTH, 64, W data width; equals the downstream per-WID FIFO WIDTH.
REQ-002 Parameter MAX_BEATS, 16, largest legal burst; equals the downstream FIFO DEPTH.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 aw_valid  input  1  write address command valid.
REQ-006 aw_ready  output  1  tracker can accept a command.
REQ-007 aw_id  input  11  burst ID.
REQ-008 aw_len  input  8  burst length minus one.
REQ-009 w_valid  input  1  write beat valid.
REQ-010 w_ready  output  1  tracker accepts the beat.
REQ-011 w_id  input  11  beat ID.
REQ-012 w_data  input  WIDTH  beat payload.
REQ-013 w_last  input  1  sender marks the final beat.
REQ-014 fifo_data  output  WIDTH  beat to the FIFO.
REQ-015 fifo_valid  output  1  push strobe to the FIFO.
REQ-016 fifo_ready  input  1  FIFO can accept a push (not full, not flushing).
REQ-017 fifo_wid  output  11  tag for the FIFO.
REQ-018 fifo_flush  output  1  one-cycle flush request.
REQ-019 fifo_flush_done  input  1  FIFO has drained.
REQ-020 busy  output  1  state is not IDLE.
REQ-021 err  output  1  sticky protocol error flag.

Function
REQ-022 The FSM SHALL have four states: IDLE, COLLECT, FLUSH and WAIT.
REQ-023 IDLE SHALL behave as follows:
- aw_ready=1.
- On aw_valid, latch aw_id into id_q and aw_len into len_q, clear cnt, go to COLLECT.
REQ-024 In COLLECT, the data path SHALL be combinational with 0-cycle latency:
- w_ready=fifo_ready.
- fifo_valid=w_valid&fifo_ready.
- fifo_data=w_data.
REQ-025 fifo_wid SHALL equal id_q in every state.
REQ-026 A beat SHALL be accepted only when w_valid&w_ready; each accepted beat increments cnt (8-bit).
REQ-027 When a beat is accepted with cnt==len_q, the FSM SHALL go to FLUSH; cnt never wraps.
REQ-028 FLUSH SHALL last exactly one cycle:
- fifo_flush=1.
- Next state is WAIT.
REQ-029 WAIT SHALL hold until fifo_flush_done=1, then go to IDLE.
- fifo_flush_done is ignored in every other state.
REQ-030 In every state except COLLECT, w_ready=0 and fifo_valid=0.
REQ-031 In every state except IDLE, aw_ready=0; a new command is never accepted before the previous flush completes.
REQ-032 When w_valid&!fifo_ready, the beat SHALL be held and not counted; cnt and state are unchanged.
REQ-033 aw_len+1 SHALL not exceed MAX_BEATS; this is an upstream obligation.
REQ-034 If fifo_ready stays 0 in COLLECT, the tracker SHALL wait indefinitely with no timeout.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL take these values:
- State IDLE.
- cnt, id_q, len_q = 0.
- err = 0.
- Outputs: aw_ready=1, w_ready=0, fifo_valid=0, fifo_flush=0, fifo_wid=0, busy=0.
REQ-036 A reset in any state SHALL abandon the burst; no flush is issued for partial data.

Configuration
REQ-037 Macro W_TRACKER_CHECK_EN SHALL control protocol checking.
- Defined: err is set and held until rst when any of these occurs:
  - An accepted beat has w_id!=id_q.
  - An accepted beat has w_last!=(cnt==len_q).
  - A command is accepted with aw_len>=MAX_BEATS.
- Defined: checking does not alter the data path or the FSM.
- Undefined: err is tied to 0; w_id and w_last are ignored; no checking logic is synthesized.

Verification
REQ-038 Single burst: aw_id=5, aw_len=3, four beats, fifo_ready=1.
- fifo_wid=5 and four fifo_valid pulses carrying the input data.
- fifo_flush=1 in the cycle after beat 4.
- WAIT until flush_done, then aw_ready=1.
REQ-039 Backpressure: aw_len=1, fifo_ready=0 for 3 cycles during beat 1.
- w_ready=0 and cnt unchanged during the stall.
- Exactly 2 pushes, then a flush.
REQ-040 Back-to-back commands: a second aw_valid is presented during WAIT.
- aw_ready=0 until flush_done is seen.
- The second command is accepted the cycle after returning to IDLE.
REQ-041 Reset mid-burst: rst after 2 of 4 beats.
- Next cycle: IDLE, aw_ready=1, fifo_flush never asserted.
REQ-042 With W_TRACKER_CHECK_EN defined:
- aw_id=7, beat with w_id=8 -> err=1 and stays 1 until rst.
- w_last on beat 2 of 4 -> err=1.
- Without the macro, the same stimulus leaves err=0.
REQ-043 Boundary: aw_len=15 with MAX_BEATS=16 -> 16 pushes, then a flush; err=0.

Source files
------------

// File: rtl/w_tracker.sv
// w_tracker: per-burst W-beat collector that forwards beats to a per-WID FIFO and requests a flush after the last beat.
// Optional protocol checking (sticky err) is enabled by defining W_TRACKER_CHECK_EN.
module w_tracker #(
  parameter int WIDTH     = 64,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aw_valid,
  output logic             aw_ready,
  input  logic [10:0]      aw_id,
  input  logic [7:0]       aw_len,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [10:0]      w_id,
  input  logic [WIDTH-1:0] w_data,
  input  logic             w_last,
  output logic [WIDTH-1:0] fifo_data,
  output logic             fifo_valid,
  input  logic             fifo_ready,
  output logic [10:0]      fifo_wid,
  output logic             fifo_flush,
  input  logic             fifo_flush_done,
  output logic             busy,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, WAIT} state_t;
  localparam logic [8:0] MAX_B = 9'(MAX_BEATS);
  state_t      state_q, state_d;
  logic [10:0] id_q, id_d;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  logic        cmd, beat, last;
  assign aw_ready   = state_q == IDLE;
  assign w_ready    = state_q == COLLECT && fifo_ready;
  assign fifo_valid = w_valid && w_ready;
  assign fifo_data  = w_data;
  assign fifo_wid   = id_q;
  assign fifo_flush = state_q == FLUSH;
  assign busy       = state_q != IDLE;
  assign cmd        = aw_valid && aw_ready;
  assign beat       = fifo_valid;
  assign last       = cnt_q == len_q;
  always_comb begin
    state_d = state_q;
    id_d    = cmd ? aw_id : id_q;
    len_d   = cmd ? aw_len : len_q;
    cnt_d   = cmd ? 8'd0 : beat && cnt_q != 8'hff ? cnt_q + 8'd1 : cnt_q;
    if (cmd) state_d = COLLECT;
    if (beat && last) state_d = FLUSH;
    if (state_q == FLUSH) state_d = WAIT;
    if (state_q == WAIT && fifo_flush_done) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef W_TRACKER_CHECK_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q | (beat && (w_id != id_q || w_last != last)) | (cmd && {1'b0, aw_len} >= MAX_B);
  end
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
`else
  logic unused_ok;
  assign unused_ok = ^{w_id, w_last, MAX_B};
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_w_tracker.sv
// tb_w_tracker: directed-vector bench for w_tracker with hand-computed expectations.
module tb_w_tracker;
`ifdef W_TRACKER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic        clk = 0, rst = 1;
  logic        aw_valid = 0, aw_ready;
  logic [10:0] aw_id = 0;
  logic [7:0]  aw_len = 0;
  logic        w_valid = 0, w_ready, w_last = 0;
  logic [10:0] w_id = 0;
  logic [63:0] w_data = 0, fifo_data;
  logic        fifo_valid, fifo_ready = 1, fifo_flush, fifo_flush_done = 0, busy, err;
  logic [10:0] fifo_wid;
  int pass_cnt = 0, chk_cnt = 0, push_cnt = 0, flush_cnt = 0;

  w_tracker #(.WIDTH(64), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id),
    .aw_len(aw_len), .w_valid(w_valid), .w_ready(w_ready), .w_id(w_id), .w_data(w_data),
    .w_last(w_last), .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .fifo_wid(fifo_wid), .fifo_flush(fifo_flush), .fifo_flush_done(fifo_flush_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_valid) push_cnt++;
    if (fifo_flush) flush_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [10:0] id, input logic [7:0] len);
    aw_valid = 1; aw_id = id; aw_len = len;
    step();
    aw_valid = 0;
  endtask

  task automatic beat(input logic [10:0] id, input logic last, input logic [63:0] d);
    w_valid = 1; w_id = id; w_last = last; w_data = d;
    #1;
    chk("beat_valid", fifo_valid, 1);
    chk("beat_data", fifo_data, d);
    step();
    w_valid = 0; w_last = 0;
  endtask

  task automatic finish_flush();
    #1;
    chk("flush_pulse", fifo_flush, 1);
    step();
    chk("wait_noflush", fifo_flush, 0);
    fifo_flush_done = 1;
    step();
    fifo_flush_done = 0;
    chk("idle_aw_ready", aw_ready, 1);
  endtask

  task automatic do_burst(input logic [10:0] id, input logic [7:0] len);
    int p0, f0;
    p0 = push_cnt; f0 = flush_cnt;
    cmd(id, len);
    chk("burst_wid", fifo_wid, 64'(id));
    chk("burst_aw_ready", aw_ready, 0);
    for (int i = 0; i <= int'(len); i++) beat(id, i == int'(len), 64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1));
    #1;
    chk("flush_pulse", fifo_flush, 1);
    chk("flush_w_ready", w_ready, 0);
    step();
    for (int i = 0; i < 2; i++) begin
      chk("wait_busy", busy, 1);
      chk("wait_aw_ready", aw_ready, 0);
      chk("wait_noflush", fifo_flush, 0);
      step();
    end
    fifo_flush_done = 1;
    step();
    fifo_flush_done = 0;
    chk("idle_aw_ready", aw_ready, 1);
    chk("idle_busy", busy, 0);
    chk("push_count", 64'(push_cnt - p0), 64'(int'(len) + 1));
    chk("flush_count", 64'(flush_cnt - f0), 1);
  endtask

  initial begin
    int f0, p0;
    w_valid = 1;
    step(); step();
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_fifo_valid", fifo_valid, 0);
    chk("rst_flush", fifo_flush, 0);
    chk("rst_wid", fifo_wid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    w_valid = 0; rst = 0;
    step();
    // single burst
    do_burst(11'd5, 8'd3);
    chk("single_err", err, 0);
    // backpressure stall on beat 1, then a second command queued during WAIT
    p0 = push_cnt;
    cmd(11'd2, 8'd1);
    fifo_ready = 0; w_valid = 1; w_id = 2; w_data = 64'h1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_w_ready", w_ready, 0);
      chk("stall_valid", fifo_valid, 0);
      step();
    end
    fifo_ready = 1;
    beat(11'd2, 0, 64'h1111);
    chk("bp_no_flush_yet", fifo_flush, 0);
    beat(11'd2, 1, 64'h2222);
    chk("bp_push_count", 64'(push_cnt - p0), 2);
    chk("bp_flush", fifo_flush, 1);
    step();
    aw_valid = 1; aw_id = 9; aw_len = 0;
    for (int i = 0; i < 2; i++) begin
      chk("b2b_aw_ready", aw_ready, 0);
      step();
    end
    chk("b2b_hold_wid", fifo_wid, 2);
    fifo_flush_done = 1;
    step();
    fifo_flush_done = 0;
    chk("b2b_idle", aw_ready, 1);
    step();
    aw_valid = 0;
    chk("b2b_accepted", busy, 1);
    chk("b2b_wid", fifo_wid, 9);
    beat(11'd9, 1, 64'h3333);
    finish_flush();
    // reset mid-burst
    f0 = flush_cnt;
    cmd(11'd3, 8'd3);
    beat(11'd3, 0, 64'h44);
    beat(11'd3, 0, 64'h55);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_aw_ready", aw_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wid", fifo_wid, 0);
    step(); step(); step();
    chk("mid_rst_no_flush", 64'(flush_cnt - f0), 0);
    // wrong beat ID
    cmd(11'd7, 8'd3);
    beat(11'd8, 0, 64'h66);
    chk("err_wid", err, CHK);
    beat(11'd7, 0, 64'h67);
    beat(11'd7, 0, 64'h68);
    beat(11'd7, 1, 64'h69);
    finish_flush();
    chk("err_sticky", err, CHK);
    rst = 1; step(); rst = 0;
    chk("err_cleared", err, 0);
    // early w_last on beat 2
    cmd(11'd7, 8'd3);
    beat(11'd7, 0, 64'h70);
    chk("err_pre_last", err, 0);
    beat(11'd7, 1, 64'h71);
    chk("err_last", err, CHK);
    beat(11'd7, 0, 64'h72);
    beat(11'd7, 1, 64'h73);
    finish_flush();
    rst = 1; step(); rst = 0;
    // boundary: 16 beats
    do_burst(11'd1, 8'd15);
    chk("boundary_err", err, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
